// File: rtl/serial_link_pkg.sv
// Shared definitions for the 1-bit serial link: FSM states, frame constants
// and the even-parity helper used by both link ends.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned FRAME_BITS = DEF_DATA_W + 3;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // XOR-reduce of the payload; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and registered full/empty flags.
module sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  logic              pop_ok;
  logic              push_ok;

  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    rd_nxt  = rd_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_nxt;
      end
      count <= count_n;
      full  <= (count_n == CNT_W'(FIFO_DEPTH));
      empty <= (count_n == '0);
      // Head follows the next stored entry, or the incoming word when it becomes the only one.
      if (pop_ok && (count > CNT_W'(1))) begin
        head <= mem[rd_nxt];
      end else if (push_ok && (empty || pop_ok)) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop deserializer feeding a small
// output FIFO drained through valid/ready.
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_i,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e         state;
  rx_state_e         state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_n;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_n;
  logic              par_bad;
  logic              par_bad_n;
  logic              parity_err_n;
  logic              frame_err_n;
  logic              overrun_n;
  logic              push_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;

  assign out_valid = ~fifo_empty;
  assign pop_c     = out_ready & ~fifo_empty;

  // Next-state, shifter and error-pulse decode.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift_q;
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    overrun_n    = 1'b0;
    push_c       = 1'b0;
    case (state)
      IDLE: begin
        if (line_i == START_BIT) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        shift_n   = (shift_q >> 1) | (DATA_W'(line_i) << (DATA_W - 1));
        bit_cnt_n = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
          state_n = PARITY;
        end
      end
      PARITY: begin
        par_bad_n = even_parity(32'(shift_q)) ^ line_i;
        state_n   = STOP;
      end
      STOP: begin
        if (line_i == STOP_BIT) begin
          state_n = IDLE;
          if (par_bad) begin
            parity_err_n = 1'b1;
          end else if (!fifo_full || pop_c) begin
            push_c = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end else begin
          frame_err_n = 1'b1;
          state_n     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (line_i == IDLE_LEVEL) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      overrun    <= overrun_n;
      busy       <= (state_n != IDLE);
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (pop_c),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: good frames, back-to-back, overrun,
// parity/framing errors and asynchronous reset mid-frame.
module tb_serial_frame_rx;
  import serial_link_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_i;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_i     (line_i),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit per clock; outputs are examined 1 ns after the sampling edge.
  task automatic send_bit(input logic b);
    line_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par_flip,
                            input logic stop_v, input logic ready_at_stop);
    logic keep;
    send_bit(START_BIT);
    for (int i = 0; i < int'(DW); i++) begin
      send_bit(d[i]);
    end
    send_bit((^d) ^ par_flip);
    keep = out_ready;
    if (ready_at_stop) out_ready = 1'b1;
    send_bit(stop_v);
    out_ready = keep;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    line_i    = IDLE_LEVEL;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    rst_n = 1'b1;
    send_bit(1'b1);

    // Single good frame with downstream ready
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    send_bit(1'b1);
    check("a5_popped", 32'(out_valid), 32'h0);

    // Back-to-back frames, downstream stalled
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("b2b_first", 32'(out_data), 32'h3C);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_head", 32'(out_data), 32'h3C);
    check("b2b_busy", 32'(busy), 32'h0);

    // Frame into a full FIFO
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'h1);
    check("ovr_head", 32'(out_data), 32'h3C);
    send_bit(1'b1);
    check("ovr_one_cycle", 32'(overrun), 32'h0);
    check("ovr_head_kept", 32'(out_data), 32'h3C);

    // Full FIFO with a pop in the stop cycle
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    check("popush_no_ovr", 32'(overrun), 32'h0);
    check("popush_head", 32'(out_data), 32'hFF);
    out_ready = 1'b1;
    send_bit(1'b1);
    check("drain_01", 32'(out_data), 32'h01);
    check("drain_01_valid", 32'(out_valid), 32'h1);
    send_bit(1'b1);
    check("drain_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Parity error then a good frame
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("par_pulse", 32'(parity_err), 32'h1);
    check("par_no_push", 32'(out_valid), 32'h0);
    check("par_excl", {30'h0, frame_err, overrun}, 32'h0);
    send_bit(1'b1);
    check("par_one_cycle", 32'(parity_err), 32'h0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    check("after_par_valid", 32'(out_valid), 32'h1);
    check("after_par_data", 32'(out_data), 32'h12);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    check("after_par_pop", 32'(out_valid), 32'h0);

    // Framing error with line held low
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    check("frm_pulse", 32'(frame_err), 32'h1);
    check("frm_excl", {30'h0, parity_err, overrun}, 32'h0);
    check("frm_busy", 32'(busy), 32'h1);
    send_bit(1'b0);
    check("frm_one_cycle", 32'(frame_err), 32'h0);
    repeat (4) send_bit(1'b0);
    check("wait_idle_busy", 32'(busy), 32'h1);
    check("wait_idle_nopush", 32'(out_valid), 32'h0);
    check("wait_idle_no_reerr", 32'(frame_err), 32'h0);
    send_bit(1'b1);
    check("wait_idle_exit", 32'(busy), 32'h0);
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);
    check("after_frm_data", 32'(out_data), 32'h66);
    check("after_frm_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of DATA with one word buffered
    send_frame(8'h10, 1'b0, 1'b1, 1'b0);
    check("pre_rst_data", 32'(out_data), 32'h10);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_data", 32'(out_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bit(1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_data", 32'(out_data), 32'h81);
    out_ready = 1'b1;
    send_bit(1'b1);
    check("post_rst_only", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
